// File: rtl/mux_pkg.sv
// Shared definitions for the selector/TDM path: FSM encodings and the elaboration-time width helper.
package mux_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } tdm_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tdm_frame_counter.sv
// Channel index counter for the TDM receiver: clear, load-to-one on a sync, or step with wrap at MAX.
module tdm_frame_counter #(
  parameter int SEL_W = 3,
  parameter int MAX   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load1,
  input  logic             clr,
  output logic [SEL_W-1:0] count,
  output logic             wrap_next
);

  logic [SEL_W-1:0] count_q, count_d;

  assign wrap_next = (count_q == SEL_W'(MAX));
  assign count     = count_q;

  // Clear beats load beats increment; increment at MAX wraps back to channel 0.
  always_comb begin
    count_d = count_q;
    if (clr)        count_d = '0;
    else if (load1) count_d = SEL_W'(1);
    else if (inc)   count_d = wrap_next ? '0 : count_q + SEL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/tdm_demux_8.sv
// TDM receiver: frame-aligns a one-channel-per-valid-cycle stream and publishes whole frames in parallel.
module tdm_demux_8
  import mux_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     frame_sync,
  output logic [NUM_CH*DATA_W-1:0] out_bus,
  output logic                     frame_strobe,
  output logic [SEL_W-1:0]         select,
  output logic                     locked,
  output logic                     sync_err
);

  if (NUM_CH < 2 || SEL_W != clog2(NUM_CH)) begin : g_bad_params
    $error("tdm_demux_8: NUM_CH must be >= 2 and SEL_W must equal clog2(NUM_CH)");
  end

  tdm_state_e                state_q, state_d;
  logic [NUM_CH*DATA_W-1:0]  shadow_q, shadow_d;
  logic [NUM_CH*DATA_W-1:0]  out_bus_q, out_bus_d;
  logic                      strobe_q, strobe_d;
  logic                      err_q, err_d;
  logic                      cnt_inc, cnt_load1, cnt_clr, wrap_next;

  tdm_frame_counter #(
    .SEL_W (SEL_W),
    .MAX   (NUM_CH - 1)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (cnt_inc),
    .load1     (cnt_load1),
    .clr       (cnt_clr),
    .count     (select),
    .wrap_next (wrap_next)
  );

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    out_bus_d = out_bus_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    cnt_inc   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_clr   = 1'b0;
    if (in_valid) begin
      if (frame_sync) begin
        // A sync always restarts the frame; mid-frame it also abandons the partial frame.
        shadow_d[0 +: DATA_W] = in_data;
        cnt_load1             = 1'b1;
        state_d               = ST_LOCKED;
        err_d                 = (state_q == ST_LOCKED) && (select != '0);
      end else if (state_q == ST_LOCKED) begin
        if (select == '0) begin
          err_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_HUNT;
        end else begin
          shadow_d[int'(select)*DATA_W +: DATA_W] = in_data;
          cnt_inc                                 = 1'b1;
          if (wrap_next) begin
            strobe_d  = 1'b1;
            out_bus_d = shadow_d;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HUNT;
      shadow_q  <= '0;
      out_bus_q <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      out_bus_q <= out_bus_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  assign out_bus      = out_bus_q;
  assign frame_strobe = strobe_q;
  assign sync_err     = err_q;
  assign locked       = (state_q == ST_LOCKED);

endmodule
